uart_rx_deser: RTL
==================

UART_RX_DESER -- requirements
Module: uart_rx_deser

Interface
REQ-001 Parameter WIDTH, default 8, data bits per frame.
REQ-002 CLK  input  1  oversampling clock (Prescale x baud).
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 RX_IN  input  1  serial line; idle high.
REQ-005 Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-006 PAR_EN  input  1  1 = parity bit present after data bits.
REQ-007 PAR_TYP  input  1  0 = even, 1 = odd parity.
REQ-008 RX_P_Data  output  WIDTH  received data word, LSB received first.
REQ-009 RX_D_VLD  output  1  one-cycle pulse; RX_P_Data valid this cycle.
REQ-010 PAR_ERR  output  1  parity mismatch on the last frame.
REQ-011 STP_ERR  output  1  stop bit sampled low on the last frame.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-013 The block SHALL sit in IDLE and SHALL move to START on the first CLK with RX_IN = 0.
REQ-014 On the IDLE->START transition the block SHALL latch Prescale, PAR_EN and PAR_TYP, and these SHALL be ignored mid-frame.
REQ-015 An illegal Prescale value SHALL be treated as 8.
REQ-016 An edge counter SHALL run 0..Prescale-1 per bit, and a bit counter SHALL count data bits 0..WIDTH-1.
REQ-017 Each bit SHALL be the majority vote of samples at edge counts P/2-1, P/2 and P/2+1, where P is the latched Prescale.
REQ-018 At edge count P-1 in START: a voted 0 SHALL go to DATA; a voted 1 (glitch) SHALL go to IDLE with no flag change.
REQ-019 DATA SHALL shift voted bits LSB-first and, after WIDTH bits, SHALL go to PARITY if PAR_EN, else to STOP.
REQ-020 PARITY SHALL compare the voted bit with the XOR of the data (inverted if PAR_TYP = 1) and SHALL set PAR_ERR on mismatch.
REQ-021 STOP SHALL set STP_ERR if the voted bit is 0.
REQ-022 At edge count P-1 of STOP the FSM SHALL return to IDLE.
REQ-023 If PAR_ERR = 0 and STP_ERR = 0 for the frame, RX_D_VLD SHALL pulse high on the next CLK for exactly one cycle.
REQ-024 On an errored frame RX_D_VLD SHALL stay 0 and RX_P_Data SHALL keep its previous value.
REQ-025 RX_P_Data SHALL update only with RX_D_VLD and SHALL hold until the next valid frame.
REQ-026 PAR_ERR and STP_ERR SHALL be registered, SHALL hold their value, and SHALL clear on the next IDLE->START transition.
REQ-027 A new start bit detected on the first cycle in IDLE after STOP SHALL be accepted (back-to-back frames, no gap required).
REQ-028 All outputs SHALL be driven directly from flops.

Reset
REQ-029 RST low SHALL immediately force IDLE, clear both counters and the shift register, and set RX_P_Data = 0, RX_D_VLD = 0, PAR_ERR = 0, STP_ERR = 0.
REQ-030 A reset mid-frame SHALL discard the partial frame, and reception SHALL restart only on a fresh falling edge after release.

Configuration
REQ-031 With UART_RX_SYNC_EN defined, RX_IN SHALL pass through a 2-flop synchronizer reset to 1, adding exactly 2 CLK of latency to every sample and to RX_D_VLD.
REQ-032 Without UART_RX_SYNC_EN, RX_IN SHALL feed the FSM and sampler directly, with no added latency.

Structure
REQ-033 Package uart_rx_pkg SHALL hold the state encoding, the legal prescale constants (8/16/32) and the parity-type constants.
REQ-034 Edge counting and majority voting SHALL live in sub-module uart_rx_sampler, which outputs the voted bit and a bit-done strobe.

Verification
REQ-035 Prescale = 8, PAR_EN = 1, PAR_TYP = 0, frame 0xAA with correct parity -> single RX_D_VLD pulse, RX_P_Data = 0xAA, PAR_ERR = 0, STP_ERR = 0.
REQ-036 Prescale = 16, odd parity, 0x3C sent with a wrong parity bit -> PAR_ERR = 1, no RX_D_VLD, RX_P_Data unchanged.
REQ-037 Prescale = 8, PAR_EN = 0, 0x55 with stop bit = 0 -> STP_ERR = 1, no RX_D_VLD; the next good frame clears STP_ERR.
REQ-038 RX_IN low for 2 CLK only (Prescale = 16) -> return to IDLE, no RX_D_VLD, flags unchanged.
REQ-039 Prescale = 32, PAR_EN = 0, back-to-back 0xCC then 0x11 -> two RX_D_VLD pulses carrying 0xCC then 0x11.
REQ-040 RST asserted during DATA bit 4 of 0xF0 -> all outputs 0 immediately; a following 0x0F frame is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive deserializer.
// Holds the FSM state encoding, the legal oversampling ratios, the parity
// type constants and two small helpers (prescale legalisation, 3-way vote).
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Any ratio other than 8/16/32 falls back to 8.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_8, PRESCALE_16, PRESCALE_32: legal_prescale = p;
      default:                              legal_prescale = PRESCALE_8;
    endcase
  endfunction

  // Majority of three samples.
  function automatic logic majority3(input logic [2:0] s);
    majority3 = (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Edge counter and 3-sample majority voter for one UART bit period.
// Ports:
//   CLK, RST       oversampling clock, asynchronous active-low reset
//   rx_i           serial line (already synchronized if that option is built)
//   start_i        start bit seen in IDLE this cycle (that cycle is edge 0)
//   active_i       FSM is inside a frame
//   prescale_i     latched oversampling ratio P
//   bit_done_o     high on edge P-1 of the current bit
//   voted_o        majority of the samples at P/2-1, P/2, P/2+1
module uart_rx_sampler
  import uart_rx_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx_i,
  input  logic       start_i,
  input  logic       active_i,
  input  logic [5:0] prescale_i,
  output logic       bit_done_o,
  output logic       voted_o
);

  logic [5:0] edge_cnt_q, edge_cnt_d;
  logic [2:0] samp_q, samp_d;
  logic [5:0] mid_s;

  assign mid_s      = prescale_i >> 1;
  assign bit_done_o = active_i && (edge_cnt_q == (prescale_i - 6'd1));
  assign voted_o    = majority3(samp_q);

  // Next edge count and sample capture around the bit centre.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    samp_d     = samp_q;
    // The IDLE cycle that saw the start bit is edge 0, so START begins at 1.
    if (start_i) begin
      edge_cnt_d = 6'd1;
    end else if (bit_done_o) begin
      edge_cnt_d = 6'd0;
    end else if (active_i) begin
      edge_cnt_d = edge_cnt_q + 6'd1;
    end else begin
      edge_cnt_d = 6'd0;
    end
    if (active_i) begin
      if (edge_cnt_q == (mid_s - 6'd1)) begin
        samp_d[0] = rx_i;
      end else if (edge_cnt_q == mid_s) begin
        samp_d[1] = rx_i;
      end else if (edge_cnt_q == (mid_s + 6'd1)) begin
        samp_d[2] = rx_i;
      end else begin
        samp_d = samp_q;
      end
    end else begin
      samp_d = samp_q;
    end
  end

  // Counter and sample registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q <= 6'd0;
      samp_q     <= 3'b111;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      samp_q     <= samp_d;
    end
  end

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: oversampled start/data/parity/stop reception.
// Ports:
//   CLK        oversampling clock (Prescale x baud)
//   RST        asynchronous active-low reset
//   RX_IN      serial line, idle high
//   Prescale   oversampling ratio 8/16/32 (others act as 8), latched per frame
//   PAR_EN     parity bit present, latched per frame
//   PAR_TYP    0 even / 1 odd parity, latched per frame
//   RX_P_Data  last good data word (LSB received first)
//   RX_D_VLD   one-cycle pulse when RX_P_Data has just been updated
//   PAR_ERR    parity mismatch on the last frame
//   STP_ERR    stop bit sampled low on the last frame
// Build option: define UART_RX_SYNC_EN to insert a 2-flop synchronizer
// (reset to 1) on RX_IN, adding 2 CLK of latency.
module uart_rx_deser
  import uart_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 8
)
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic [5:0]       Prescale,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [WIDTH-1:0] RX_P_Data,
  output logic             RX_D_VLD,
  output logic             PAR_ERR,
  output logic             STP_ERR
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;
  // Two-flop synchronizer; resets to the idle level.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RX_IN};
    end
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = RX_IN;
`endif

  state_e             state_q, state_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [5:0]         pres_q, pres_d;
  logic               pen_q, pen_d;
  logic               ptyp_q, ptyp_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               vld_q, vld_d;
  logic               par_err_q, par_err_d;
  logic               stp_err_q, stp_err_d;
  logic               rx_prev_q;
  logic               start_s, bit_done_s, voted_s, exp_par_s;

  // Starts need a falling edge; rx_prev_q resets low so a line still low
  // after reset release is not mistaken for a start bit.
  assign start_s   = (state_q == ST_IDLE) && !rx_s && rx_prev_q;
  assign exp_par_s = (^shift_q) ^ (ptyp_q == PAR_ODD);

  uart_rx_sampler u_sampler (
    .CLK        (CLK),
    .RST        (RST),
    .rx_i       (rx_s),
    .start_i    (start_s),
    .active_i   (state_q != ST_IDLE),
    .prescale_i (pres_q),
    .bit_done_o (bit_done_s),
    .voted_o    (voted_s)
  );

  // Next-state and register updates for the frame FSM.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pres_d    = pres_q;
    pen_d     = pen_q;
    ptyp_d    = ptyp_q;
    data_d    = data_q;
    vld_d     = 1'b0;
    par_err_d = par_err_q;
    stp_err_d = stp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d   = ST_START;
          pres_d    = legal_prescale(Prescale);
          pen_d     = PAR_EN;
          ptyp_d    = PAR_TYP;
          bit_cnt_d = '0;
          par_err_d = 1'b0;
          stp_err_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_done_s) begin
          state_d = voted_s ? ST_IDLE : ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          shift_d = {voted_s, shift_q[WIDTH-1:1]};
          if (bit_cnt_q == BCW'(WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = pen_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_done_s) begin
          par_err_d = (voted_s != exp_par_s);
          state_d   = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_done_s) begin
          stp_err_d = !voted_s;
          state_d   = ST_IDLE;
          if (voted_s && !par_err_q) begin
            vld_d  = 1'b1;
            data_d = shift_q;
          end else begin
            vld_d = 1'b0;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      pres_q    <= PRESCALE_8;
      pen_q     <= 1'b0;
      ptyp_q    <= PAR_EVEN;
      data_q    <= '0;
      vld_q     <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      rx_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      pres_q    <= pres_d;
      pen_q     <= pen_d;
      ptyp_q    <= ptyp_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
      rx_prev_q <= rx_s;
    end
  end

  assign RX_P_Data = data_q;
  assign RX_D_VLD  = vld_q;
  assign PAR_ERR   = par_err_q;
  assign STP_ERR   = stp_err_q;

endmodule
